// File: rtl/sram_arb.sv
// sram_arb: two-requester arbiter/sequencer for a shared simple-dual-port SRAM.
// The write and read ports are arbitrated independently, each by its own
// round-robin pointer. Read data returns one cycle after the grant. A write
// granted in the same cycle to the same address is forwarded to the read.
module sram_arb #(
    parameter int unsigned DWIDTH = 24,
    parameter int unsigned AWIDTH = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [AWIDTH-1:0] a_addr,
    input  logic [DWIDTH-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DWIDTH-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [AWIDTH-1:0] b_addr,
    input  logic [DWIDTH-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DWIDTH-1:0] b_rdata,
    output logic              sram_we,
    output logic [AWIDTH-1:0] sram_addr_w,
    output logic [DWIDTH-1:0] sram_data_i,
    output logic [AWIDTH-1:0] sram_addr_r,
    input  logic [DWIDTH-1:0] sram_data_o
);

    // Round-robin pointers (0 = A favoured, 1 = B favoured) and read pipeline state
    logic              wr_pri;
    logic              rd_pri;
    logic              rd_v;
    logic              rd_id;
    logic              fwd;
    logic [DWIDTH-1:0] fwd_data;

    // Contender flags and per-port grants
    logic wr_a, wr_b, rd_a, rd_b;
    logic wg_a, wg_b, rg_a, rg_b;
    logic wr_any, rd_any, wr_cont, rd_cont, hit;

    // Independent write/read arbitration: sole contender wins, a tie goes to the pointer
    always_comb begin
        wr_a    = a_req & a_we;
        wr_b    = b_req & b_we;
        rd_a    = a_req & ~a_we;
        rd_b    = b_req & ~b_we;
        wg_a    = wr_a & (~wr_b | ~wr_pri);
        wg_b    = wr_b & (~wr_a |  wr_pri);
        rg_a    = rd_a & (~rd_b | ~rd_pri);
        rg_b    = rd_b & (~rd_a |  rd_pri);
        wr_any  = wg_a | wg_b;
        rd_any  = rg_a | rg_b;
        wr_cont = wr_a & wr_b;
        rd_cont = rd_a & rd_b;
    end

    // SRAM port steering; idle ports park on requester A's address/data
    always_comb begin
        a_gnt       = wg_a | rg_a;
        b_gnt       = wg_b | rg_b;
        sram_we     = wr_any;
        sram_addr_w = wg_b ? b_addr  : a_addr;
        sram_data_i = wg_b ? b_wdata : a_wdata;
        sram_addr_r = rg_b ? b_addr  : a_addr;
        hit         = rd_any & wr_any & (sram_addr_r == sram_addr_w);
    end

    // Pointer update on contended grants plus read-return/forward pipeline
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_pri   <= 1'b0;
            rd_pri   <= 1'b0;
            rd_v     <= 1'b0;
            rd_id    <= 1'b0;
            fwd      <= 1'b0;
            fwd_data <= '0;
        end else begin
            if (wr_cont) begin
                wr_pri <= ~wr_pri;
            end
            if (rd_cont) begin
                rd_pri <= ~rd_pri;
            end
            rd_v  <= rd_any;
            rd_id <= rg_b;
            fwd   <= hit;
            if (hit) begin
                fwd_data <= sram_data_i;
            end
        end
    end

    // Read return: one shared data bus, valid steered to the requester that was granted
    always_comb begin
        a_rvalid = rd_v & ~rd_id;
        b_rvalid = rd_v &  rd_id;
        a_rdata  = fwd ? fwd_data : sram_data_o;
        b_rdata  = fwd ? fwd_data : sram_data_o;
    end

endmodule

// File: tb/tb_sram_arb.sv
// tb_sram_arb: directed plus randomized bench for sram_arb with an SRAM model,
// a reference model of the arbitration rules, and a read-response scoreboard.
module tb_sram_arb;

    localparam int unsigned DW    = 24;
    localparam int unsigned AW    = 6;
    localparam int unsigned DEPTH = 64;

    logic          clk;
    logic          rst;
    logic          a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_gnt, b_gnt, a_rvalid, b_rvalid;
    logic [DW-1:0] a_rdata, b_rdata;
    logic          sram_we;
    logic [AW-1:0] sram_addr_w, sram_addr_r;
    logic [DW-1:0] sram_data_i, sram_data_o;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    sram_arb #(.DWIDTH(DW), .AWIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .sram_we(sram_we), .sram_addr_w(sram_addr_w), .sram_data_i(sram_data_i),
        .sram_addr_r(sram_addr_r), .sram_data_o(sram_data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: write at the edge, registered read of the pre-edge content
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (sram_we) mem[sram_addr_w] <= sram_data_i;
        sram_data_o <= mem[sram_addr_r];
    end

    function automatic logic [DW-1:0] init_val(input int i);
        return DW'(i ^ 6);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: memory image, who is favoured next on each port, expected grants
    typedef struct {
        int            stamp;
        bit            id;
        logic [DW-1:0] data;
    } rsp_t;
    rsp_t          sb[$];
    logic [DW-1:0] ref_mem [DEPTH];
    bit            wr_fav = 1'b0;
    bit            rd_fav = 1'b0;
    bit            exp_a_gnt = 1'b0;
    bit            exp_b_gnt = 1'b0;

    // Checker: predicts grants and SRAM port values, queues the expected read reply
    always @(negedge clk) begin
        bit want_wa, want_wb, want_ra, want_rb;
        bit w_is_b, r_is_b, w_on, r_on;
        logic [AW-1:0] w_addr, r_addr;
        logic [DW-1:0] w_data, r_data;
        rsp_t item;
        if (rst) begin
            wr_fav = 1'b0;
            rd_fav = 1'b0;
            exp_a_gnt = 1'b0;
            exp_b_gnt = 1'b0;
        end else begin
            want_wa = a_req && a_we;
            want_wb = b_req && b_we;
            want_ra = a_req && !a_we;
            want_rb = b_req && !b_we;
            w_on = want_wa || want_wb;
            r_on = want_ra || want_rb;
            if (want_wa && want_wb) begin
                w_is_b = wr_fav;
                wr_fav = !w_is_b;
            end else begin
                w_is_b = want_wb;
            end
            if (want_ra && want_rb) begin
                r_is_b = rd_fav;
                rd_fav = !r_is_b;
            end else begin
                r_is_b = want_rb;
            end
            exp_a_gnt = (w_on && !w_is_b) || (r_on && !r_is_b);
            exp_b_gnt = (w_on && w_is_b) || (r_on && r_is_b);
            w_addr = w_is_b ? b_addr : a_addr;
            w_data = w_is_b ? b_wdata : a_wdata;
            r_addr = r_is_b ? b_addr : a_addr;
            chk("a_gnt", 32'(a_gnt), 32'(exp_a_gnt));
            chk("b_gnt", 32'(b_gnt), 32'(exp_b_gnt));
            chk("sram_we", 32'(sram_we), 32'(w_on));
            if (w_on) begin
                chk("sram_addr_w", 32'(sram_addr_w), 32'(w_addr));
                chk("sram_data_i", 32'(sram_data_i), 32'(w_data));
            end
            if (r_on) begin
                chk("sram_addr_r", 32'(sram_addr_r), 32'(r_addr));
                r_data = (w_on && w_addr == r_addr) ? w_data : ref_mem[r_addr];
                item.stamp = cyc + 1;
                item.id    = r_is_b;
                item.data  = r_data;
                sb.push_back(item);
            end
            if (w_on) ref_mem[w_addr] = w_data;
        end
    end

    // Monitor: every presented read reply must match the oldest expected one
    always @(negedge clk) begin
        rsp_t item;
        if (rst) begin
            chk("rst_a_rvalid", 32'(a_rvalid), 0);
            chk("rst_b_rvalid", 32'(b_rvalid), 0);
            sb.delete();
        end else if (a_rvalid || b_rvalid) begin
            chk("single_rvalid", 32'(a_rvalid && b_rvalid), 0);
            if (sb.size() == 0 || sb[0].stamp != cyc) begin
                chk("unexpected_rvalid", 32'(a_rvalid | b_rvalid), 0);
            end else begin
                item = sb.pop_front();
                chk("rsp_id", 32'(b_rvalid), 32'(item.id));
                chk("rsp_data", 32'(item.id ? b_rdata : a_rdata), 32'(item.data));
            end
        end else if (sb.size() != 0 && sb[0].stamp == cyc) begin
            item = sb.pop_front();
            chk("missing_rvalid", 0, 1);
        end
    end

    task automatic set_a(input logic r, input logic w, input int ad, input logic [31:0] d);
        a_req = r; a_we = w; a_addr = AW'(ad); a_wdata = DW'(d);
    endtask

    task automatic set_b(input logic r, input logic w, input int ad, input logic [31:0] d);
        b_req = r; b_we = w; b_addr = AW'(ad); b_wdata = DW'(d);
    endtask

    task automatic idle();
        set_a(1'b0, 1'b0, 0, 0);
        set_b(1'b0, 1'b0, 0, 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [DW-1:0] seq_exp [4];
    bit pa, pb;

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i]     = init_val(i);
            ref_mem[i] = init_val(i);
        end
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_a_rvalid", 32'(a_rvalid), 0);
        chk("reset_b_rvalid", 32'(b_rvalid), 0);
        chk("reset_sram_we", 32'(sram_we), 0);
        step();
        rst = 1'b0;

        // A writes then reads back address 5
        set_a(1'b1, 1'b1, 5, 'h123456);
        @(negedge clk);
        chk("wr5_gnt", 32'(a_gnt), 1);
        chk("wr5_we", 32'(sram_we), 1);
        chk("wr5_addr", 32'(sram_addr_w), 5);
        step();
        set_a(1'b1, 1'b0, 5, 0);
        @(negedge clk);
        chk("rd5_gnt", 32'(a_gnt), 1);
        step();
        idle();
        @(negedge clk);
        chk("rd5_rvalid", 32'(a_rvalid), 1);
        chk("rd5_rdata", 32'(a_rdata), 'h123456);
        step();

        // Contended writes alternate A, B, A, B
        set_a(1'b1, 1'b1, 1, 'hAAAAAA);
        set_b(1'b1, 1'b1, 2, 'hBBBBBB);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("alt_wr_a", 32'(a_gnt), 32'(i % 2 == 0));
            chk("alt_wr_b", 32'(b_gnt), 32'(i % 2 == 1));
            step();
        end
        // Contended reads alternate A, B, A, B
        set_a(1'b1, 1'b0, 1, 0);
        set_b(1'b1, 1'b0, 2, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("alt_rd_a", 32'(a_gnt), 32'(i % 2 == 0));
            chk("alt_rd_b", 32'(b_gnt), 32'(i % 2 == 1));
            step();
        end
        idle();
        step();

        // Same-address write/read forwards; different address reads SRAM
        set_a(1'b1, 1'b1, 7, 'h0F0F0F);
        set_b(1'b1, 1'b0, 7, 0);
        @(negedge clk);
        chk("fwd_both_gnt", 32'(a_gnt & b_gnt), 1);
        step();
        idle();
        @(negedge clk);
        chk("fwd_rvalid", 32'(b_rvalid), 1);
        chk("fwd_rdata", 32'(b_rdata), 'h0F0F0F);
        step();
        set_a(1'b1, 1'b1, 7, 'h0F0F0F);
        set_b(1'b1, 1'b0, 8, 0);
        step();
        idle();
        @(negedge clk);
        chk("nofwd_rvalid", 32'(b_rvalid), 1);
        chk("nofwd_rdata", 32'(b_rdata), 32'(init_val(8)));
        step();

        // B streams reads of 0..3 back-to-back
        seq_exp[0] = init_val(0);
        seq_exp[1] = 24'hAAAAAA;
        seq_exp[2] = 24'hBBBBBB;
        seq_exp[3] = init_val(3);
        for (int k = 0; k < 5; k++) begin
            if (k < 4) set_b(1'b1, 1'b0, k, 0);
            else       set_b(1'b0, 1'b0, 0, 0);
            @(negedge clk);
            if (k < 4) chk("stream_gnt", 32'(b_gnt), 1);
            if (k > 0) begin
                chk("stream_rvalid", 32'(b_rvalid), 1);
                chk("stream_rdata", 32'(b_rdata), 32'(seq_exp[k-1]));
            end
            chk("stream_a_quiet", 32'(a_rvalid), 0);
            step();
        end

        // Uncontended grant leaves the write pointer alone
        set_a(1'b1, 1'b1, 9, 'h111111);
        @(negedge clk);
        chk("unc_wr_a", 32'(a_gnt), 1);
        step();
        set_a(1'b1, 1'b1, 10, 'h222222);
        set_b(1'b1, 1'b1, 11, 'h333333);
        @(negedge clk);
        chk("cont1_a", 32'(a_gnt), 1);
        chk("cont1_b", 32'(b_gnt), 0);
        step();
        @(negedge clk);
        chk("cont2_a", 32'(a_gnt), 0);
        chk("cont2_b", 32'(b_gnt), 1);
        step();

        // Reset drops a pending read response and restores the read pointer
        set_a(1'b1, 1'b0, 3, 0);
        set_b(1'b1, 1'b0, 4, 0);
        @(negedge clk);
        chk("prerst_rd_a", 32'(a_gnt), 1);
        step();
        set_b(1'b0, 1'b0, 0, 0);
        @(negedge clk);
        chk("prerst_rd_a2", 32'(a_gnt), 1);
        step();
        idle();
        chk("prerst_rvalid", 32'(a_rvalid), 1);
        rst = 1'b1;
        #1;
        chk("rst_async_rvalid", 32'(a_rvalid), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_a(1'b1, 1'b0, 5, 0);
        set_b(1'b1, 1'b0, 6, 0);
        @(negedge clk);
        chk("postrst_rd_a", 32'(a_gnt), 1);
        chk("postrst_rd_b", 32'(b_gnt), 0);
        step();
        idle();
        step();

        // Randomized traffic; each requester holds its op until granted
        pa = 1'b0;
        pb = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (!pa || exp_a_gnt) begin
                pa = ($urandom_range(0, 3) != 0);
                set_a(pa, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), $urandom);
            end
            if (!pb || exp_b_gnt) begin
                pb = ($urandom_range(0, 3) != 0);
                set_b(pb, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), $urandom);
            end
            @(negedge clk);
            step();
        end
        idle();
        repeat (3) step();
        chk("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_arb.md
Name: sram_arb

Overview:
- Two-requester arbiter and sequencer for the shared simple-dual-port weight/activation SRAM.
- Requester A and requester B each issue single-beat read or write ops.
- The write port and read port are arbitrated independently, each with its own round-robin pointer.
- Read data is returned with a 1-cycle latency. A granted write to the same address in the same cycle is forwarded to the read, so reads always see newest data.

Parameters:
- DWIDTH, 24, data word width (matches SRAM).
- AWIDTH, 6, address width (SRAM depth 2**AWIDTH).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- a_req  in  1  requester A op valid
- a_we  in  1  A op type: 1 = write, 0 = read
- a_addr  in  AWIDTH  A address
- a_wdata  in  DWIDTH  A write data
- a_gnt  out  1  A op accepted this cycle (combinational)
- a_rvalid  out  1  A read data valid
- a_rdata  out  DWIDTH  A read data
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as A, for requester B
- sram_we  out  1  to SRAM we
- sram_addr_w  out  AWIDTH  to SRAM addr_w
- sram_data_i  out  DWIDTH  to SRAM data_i
- sram_addr_r  out  AWIDTH  to SRAM addr_r
- sram_data_o  in  DWIDTH  from SRAM data_o (registered, 1-cycle read latency)

Behaviour:
- Op acceptance:
  - An op is accepted when req & gnt.
  - Requester holds req/we/addr/wdata stable until gnt.
  - Each requester has at most one op per cycle.
- Write contenders are req & we; read contenders are req & ~we. The two arbiters are independent: A reading while B writes grants both in the same cycle.
- Per arbiter:
  - Only one contender: that contender wins.
  - Both contend: the winner is the one selected by the pointer (wr_pri / rd_pri, 0 = A, 1 = B).
  - After a contended grant, the pointer moves to the loser.
  - Uncontended grants leave the pointer unchanged.
- gnt:
  - gnt = write-grant OR read-grant for that requester; purely combinational from req/we/pointer.
  - No gnt when req = 0.
- Write path (combinational):
  - sram_we = 1 iff a write is granted.
  - sram_addr_w and sram_data_i come from the winner.
  - When idle: sram_we = 0, and addr/data hold the A inputs (don't-care).
- Read path:
  - sram_addr_r = winner addr (A addr when idle).
  - Registered at the edge: rd_v, rd_id (0 = A, 1 = B), fwd, fwd_data.
  - fwd = 1 when a read and a write are granted in the same cycle with addr_r == addr_w; fwd_data then captures the write data.
  - Next cycle: x_rvalid = rd_v & (rd_id == x).
  - x_rdata = fwd ? fwd_data : sram_data_o, driven to both requesters (valid only with rvalid).
- Latency:
  - Read granted in cycle N: rvalid and rdata in cycle N+1, exactly 1 cycle wide.
  - Back-to-back reads sustain 1 per cycle.
  - Write is committed at the grant edge; a read granted at N+1 or later to that address returns the new data from the SRAM.
- Reset (async assert, sync-safe deassert):
  - wr_pri = 0, rd_pri = 0, rd_v = 0, rd_id = 0, fwd = 0, fwd_data = 0.
  - Hence a_rvalid = b_rvalid = 0.
  - Rdata outputs follow fwd = 0, i.e. pass sram_data_o.
- Reset mid-read: a read granted in the cycle reset asserts produces no rvalid; the pending response is dropped.
- SRAM contents are not cleared by this block.
- Same-cycle write by A and read by B to different addresses: no forward; B gets the old SRAM content at that address.

Test Plan:
- Reset → a_rvalid = b_rvalid = 0, sram_we = 0. Then A writes 0x123456 @ addr 5 → a_gnt = 1, sram_we = 1, sram_addr_w = 5. A reads addr 5 the next cycle → a_rvalid = 1 one cycle later, a_rdata = 0x123456.
- A and B both write continuously (A: 0xAAAAAA @1, B: 0xBBBBBB @2) for 4 cycles → grants alternate A, B, A, B starting with A. Same pattern for dual reads.
- Same cycle: A writes 0x0F0F0F @ 7, B reads addr 7 (old content 0x000001) → b_rvalid next cycle with b_rdata = 0x0F0F0F (forwarded). Repeat with B reading addr 8 → returns SRAM content of addr 8, no forward.
- B issues reads to addr 0..3 on consecutive cycles, A idle → b_gnt = 1 every cycle, b_rvalid high 4 consecutive cycles, data in address order, a_rvalid stays 0.
- Uncontended A write, then contended write → pointer unchanged by the uncontended grant, so A wins the contended cycle, then B.
- Assert rst in the cycle after A's read grant → a_rvalid drops to 0 immediately (async). After release, the first contended read is granted to A.
